// File: rtl/down_timer.sv
// Loadable down-counter/timer with a one-cycle expiry pulse and optional auto-reload.
// Define DOWN_TIMER_EXPIRY_COUNT_EN to add a saturating 8-bit expiry counter output.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             zero
`ifdef DOWN_TIMER_EXPIRY_COUNT_EN
    ,
    output logic [7:0]       expiry_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            out_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Load wins over enable; expiry either stops at zero or restarts from the reload register.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            reload_d = load_value;
            out_d    = load_value;
            state_d  = (load_value != '0) ? RUN : IDLE;
        end else if (state_q == RUN && enable) begin
            if (out_q > WIDTH'(1)) begin
                out_d = out_q - WIDTH'(1);
            end else if (auto_reload) begin
                out_d  = reload_q;
                done_d = 1'b1;
            end else begin
                out_d   = '0;
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

`ifdef DOWN_TIMER_EXPIRY_COUNT_EN
    logic [7:0] exp_cnt_q;

    // Counts expiries since reset; load does not clear it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_cnt_q <= '0;
        end else if (done_d && exp_cnt_q != 8'hFF) begin
            exp_cnt_q <= exp_cnt_q + 8'd1;
        end
    end

    assign expiry_count = exp_cnt_q;
`endif

    assign out  = out_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
    assign zero = (out_q == '0);

endmodule
